// File: rtl/bram_line_streamer.sv
// bram_line_streamer: reads a stored waveform cyclically from bram_interface in generator mode
// and replays it as an AXI-Stream master, hiding the read latency behind a credit-managed FIFO.
`ifndef WD_DATA_WIDTH
`define WD_DATA_WIDTH 32
`endif
module bram_line_streamer #(
    parameter int DATA_WIDTH = `WD_DATA_WIDTH,
    parameter int BRAM_DEPTH = 500,
    parameter int BRAM_DELAY = 3,
    localparam int FIFO_DEPTH = BRAM_DELAY + 2,
    localparam int LCW = $clog2(BRAM_DEPTH) + 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1),
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [LCW-1:0]        line_count,
    input  logic                  write_rdy,
    input  logic [DATA_WIDTH-1:0] line_out,
    input  logic                  valid_line_out,
    output logic                  generator_mode,
    output logic                  rst_gen_mode,
    output logic                  next,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  stray_err
);
    typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [LCW-1:0]        lc_q, lc_d, iss_q, iss_d, out_q, out_d;
    logic [CW-1:0]         credits_q, credits_d, inflight_q, inflight_d, cnt_q, cnt_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic                  wrap_q, wrap_d, stray_q, stray_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic                  pop, push;

    assign m_tvalid  = cnt_q != '0;
    assign m_tdata   = mem_q[rd_q];
    assign m_tlast   = m_tvalid & (out_q == lc_q - 1'b1);
    assign busy      = state_q != IDLE;
    assign stray_err = stray_q;
    assign pop       = m_tvalid & m_tready;
    assign push      = valid_line_out & (inflight_q != '0);

    always_comb begin
        state_d        = state_q;
        lc_d           = lc_q;
        iss_d          = iss_q;
        wrap_d         = wrap_q;
        generator_mode = 1'b0;
        rst_gen_mode   = 1'b0;
        next           = 1'b0;
        out_d          = pop ? ((out_q == lc_q - 1'b1) ? '0 : out_q + 1'b1) : out_q;
        case (state_q)
            IDLE: begin
                if (run && write_rdy && line_count != '0 && line_count <= LCW'(BRAM_DEPTH)) begin
                    state_d = START;
                    lc_d    = line_count;
                end
            end
            START: begin
                generator_mode = 1'b1;
                rst_gen_mode   = 1'b1;
                iss_d          = '0;
                out_d          = '0;
                wrap_d         = 1'b0;
                state_d        = STREAM;
            end
            STREAM: begin
                generator_mode = 1'b1;
                rst_gen_mode   = wrap_q;
                next           = !wrap_q && credits_q < CW'(FIFO_DEPTH);
                // issuing the last line schedules the pointer-reset pulse for the next cycle
                wrap_d         = next && iss_q == lc_q - 1'b1;
                iss_d          = next ? (wrap_d ? '0 : iss_q + 1'b1) : iss_q;
                state_d        = run ? STREAM : DRAIN;
            end
            default: begin
                generator_mode = 1'b1;
                wrap_d         = 1'b0;
                state_d        = (credits_q == '0) ? IDLE : DRAIN;
            end
        endcase
        credits_d  = credits_q + CW'(next) - CW'(pop);
        inflight_d = inflight_q + CW'(next) - CW'(push);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        wr_d       = push ? ((wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d       = pop ? ((rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        stray_d    = stray_q | (valid_line_out & (inflight_q == '0));
        mem_d      = mem_q;
        if (push) mem_d[wr_q] = line_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lc_q       <= '0;
            iss_q      <= '0;
            out_q      <= '0;
            credits_q  <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            wrap_q     <= 1'b0;
            stray_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            lc_q       <= lc_d;
            iss_q      <= iss_d;
            out_q      <= out_d;
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            wrap_q     <= wrap_d;
            stray_q    <= stray_d;
            mem_q      <= mem_d;
        end
    end
endmodule
